otp_stream_cryptor: RTL and testbench
=====================================

# otp_stream_cryptor

Parametrised one-time-pad stream encryptor/decryptor. It XORs a framed message stream with a separate key-pad stream, one word per cycle, using valid/ready handshakes on all three streams. It also tracks pad consumption so no pad word is ever used twice, and refuses frames that would overrun the remaining pad. It sits between the message source and the channel/sink, with the pad supplier on its own stream; since encryption and decryption are both plain XOR, the same block serves both directions.

## Interface
- WORD_W, 16: width of message/key/output words in bits
- MSG_WORDS, 15: maximum frame length in words (default 240-bit message)
- PAD_WORDS, 64: total pad words available between resets
- LEN_W, $clog2(MSG_WORDS+1): width of frame length port
- PAD_W, $clog2(PAD_WORDS+1): width of pad counter

- clk  in  1  rising-edge clock (the block's only clock)
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request, sampled only in IDLE
- len  in  LEN_W  frame length in words, sampled with start
- in_valid  in  1  message word valid
- in_ready  out  1  message word accepted this cycle
- in_data  in  WORD_W  message word
- key_valid  in  1  pad word valid
- key_ready  out  1  pad word accepted this cycle
- key_data  in  WORD_W  pad word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output word
- out_data  out  WORD_W  in_data ^ key_data, registered
- out_last  out  1  marks final word of frame
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when frame fully delivered
- err  out  1  one-cycle pulse on rejected start
- pad_left  out  PAD_W  unused pad words remaining

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Reject if len==0, len>MSG_WORDS, or len>pad_left: err=1 next cycle, stay IDLE, nothing consumed.
  - Otherwise load remaining-word counter with len and go to RUN.
- RUN:
  - Define take = in_valid && key_valid && (!out_valid || out_ready).
  - in_ready = key_ready = take, asserted together only in RUN. A message word is never consumed without its pad word, and vice versa.
  - Upstream valids must not depend on ready.
  - On take: out_data <= in_data ^ key_data, out_valid <= 1, out_last <= (remaining==1), remaining -= 1, pad_left -= 1.
  - When remaining reaches 0, no further take until the next frame.
  - On out_valid && out_ready && !take: out_valid <= 0.
  - On out_valid && out_ready && out_last: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- out_data/out_last hold stable while out_valid && !out_ready.
- start in RUN or DONE is ignored; err is not raised.
- pad_left never wraps; it saturates at 0 by construction because frames exceeding it are rejected.
- Pad reload happens only via rst.

## Timing
- Reset values: in_ready=0, key_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0, pad_left=PAD_WORDS, state=IDLE, remaining=0.
- rst mid-frame:
  - Frame is abandoned and all outputs return to reset values next cycle.
  - Pad counter restores to PAD_WORDS; the new pad is expected after reset.
- start accepted in cycle N: busy=1 from N+1; first take possible in N+1.
- Latency: input pair taken in cycle N appears on out_data in cycle N+1.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous out_ready && take: old word leaves and new word loads in the same cycle; no bubble.
- Last word taken in cycle N, accepted downstream in cycle M≥N+1: done=1 in cycle M+1, busy=0 in cycle M+1, IDLE in M+2 (start accepted from M+2).
- err pulse appears in the cycle after the rejected start.

## Test plan
- Basic XOR, len=5, out_ready=1:
  - Stimulus pairs (0000,FFFF), (FFFF,FFFF), (AAAA,5555), (5555,5555), (FFFF,5555).
  - Required: out FFFF, 0000, FFFF, 0000, AAAA on consecutive cycles; out_last only on the 5th; done one cycle after it; pad_left=59.
- Backpressure:
  - out_ready low for 3 cycles mid-frame.
  - Required: out_data held stable, in_ready/key_ready=0 while the register is full, no word lost or duplicated.
- Stream skew:
  - key_valid delayed 4 cycles behind in_valid.
  - Required: no take until both valid; message words matched to pad words in order.
- Rejections:
  - len=0, len=16, and len=10 with pad_left=4 (after 60 words used).
  - Required: err pulse each time, pad_left unchanged, state IDLE.
- Pad exhaustion:
  - Frames of 15,15,15,15,4.
  - Required: all accepted, pad_left=0; any further start gives err.
- Reset mid-frame:
  - rst after 2 of 8 words.
  - Required: all outputs at reset values next cycle, pad_left=64, and a new frame runs correctly.

Source files
------------

// File: rtl/otp_stream_cryptor.sv
// otp_stream_cryptor
//
// One-time-pad stream cipher. Each message word is XORed with exactly one pad
// word and the result is registered toward the sink. Encryption and decryption
// are the same operation. The block counts how many pad words are left. It
// refuses any frame that is empty, longer than MSG_WORDS, or longer than the
// remaining pad, so a pad word can never be reused. Only rst restores the pad
// count.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, len            frame request and its length in words (IDLE only)
//   in_valid/in_ready/in_data     message stream
//   key_valid/key_ready/key_data  pad stream (consumed in lock-step with message)
//   out_valid/out_ready/out_data  ciphertext/plaintext stream, out_last on final word
//   busy                  frame in progress
//   done                  one-cycle pulse after the final word is delivered
//   err                   one-cycle pulse after a rejected start
//   pad_left              unused pad words remaining
module otp_stream_cryptor #(
    parameter int WORD_W    = 16,
    parameter int MSG_WORDS = 15,
    parameter int PAD_WORDS = 64,
    parameter int LEN_W     = $clog2(MSG_WORDS + 1),
    parameter int PAD_W     = $clog2(PAD_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [WORD_W-1:0] key_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PAD_W-1:0]  pad_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [WORD_W-1:0] data_p1;
    logic              vld_p1;
    logic              last_p1;
    logic              take;
    logic              fire_out;
    logic              start_ok;
    logic              start_bad;

    // A frame is legal only if it is non-empty, fits the frame limit and
    // fits in the pad that is still unused.
    function automatic logic len_ok(input logic [LEN_W-1:0] l,
                                    input logic [PAD_W-1:0] left);
        logic [31:0] l32;
        logic [31:0] left32;
        l32    = 32'(l);
        left32 = 32'(left);
        return (l32 != 32'd0) && (l32 <= 32'(MSG_WORDS)) && (l32 <= left32);
    endfunction

    assign start_ok  = (state == IDLE) && start && len_ok(len, pad_left);
    assign start_bad = (state == IDLE) && start && !len_ok(len, pad_left);

    // A word pair is taken only when both streams offer data and the output
    // register is empty or being emptied in the same cycle.
    assign take     = (state == RUN) && (remaining != '0) && in_valid && key_valid
                      && (!vld_p1 || out_ready);
    assign fire_out = vld_p1 && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN:  if (fire_out && last_p1) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = take;
        key_ready = take;
        busy      = (state == RUN);
        done      = (state == DONE);
    end

    // Frame and pad accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            pad_left  <= PAD_W'(PAD_WORDS);
            err       <= 1'b0;
        end else begin
            err <= start_bad;
            if (start_ok) begin
                remaining <= len;
            end else if (take) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (take) begin
                pad_left <= pad_left - PAD_W'(1);
            end
        end
    end

    // Stage p1: registered XOR result, held while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (take) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data ^ key_data;
            last_p1 <= (remaining == LEN_W'(1));
        end else if (fire_out) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_otp_stream_cryptor.sv
// Directed bench for otp_stream_cryptor: a table of basic XOR vectors plus
// hand-written sequences for backpressure, stream skew, rejections, reset
// mid-frame and pad exhaustion. A small scoreboard records every taken pair
// and compares it with the word the sink accepts.
module tb_otp_stream_cryptor;

    localparam int WORD_W    = 16;
    localparam int MSG_WORDS = 15;
    localparam int PAD_WORDS = 64;
    localparam int LEN_W     = $clog2(MSG_WORDS + 1);
    localparam int PAD_W     = $clog2(PAD_WORDS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              key_valid;
    logic              key_ready;
    logic [WORD_W-1:0] key_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [PAD_W-1:0]  pad_left;

    int checks = 0;
    int errors = 0;
    int pad_model;
    int model_rem;
    logic [WORD_W-1:0] exp_q[$];
    logic              last_q[$];

    typedef struct {
        logic [WORD_W-1:0] din;
        logic [WORD_W-1:0] key;
        logic [WORD_W-1:0] exp;
    } vec_t;

    vec_t tbl[5];

    otp_stream_cryptor #(
        .WORD_W    (WORD_W),
        .MSG_WORDS (MSG_WORDS),
        .PAD_WORDS (PAD_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_data  (key_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pad_left  (pad_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; sample just before the edge,
    // update the scoreboard, then advance to 1 ns after the edge.
    task automatic cyc(output logic took);
        logic              acc;
        logic              stall;
        logic              ol;
        logic [WORD_W-1:0] od;
        #1;
        took  = in_ready && in_valid && key_valid;
        acc   = out_valid && out_ready;
        stall = out_valid && !out_ready;
        od    = out_data;
        ol    = out_last;
        check("ready_pair", 32'(in_ready), 32'(key_ready));
        check("take_rule", 32'(in_ready && (!in_valid || !key_valid || stall)), 32'(0));
        if (acc) begin
            check("out_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                check("sb_data", 32'(od), 32'(exp_q.pop_front()));
                check("sb_last", 32'(ol), 32'(last_q.pop_front()));
            end
        end
        if (took) begin
            exp_q.push_back(in_data ^ key_data);
            last_q.push_back(model_rem == 1);
            model_rem--;
            pad_model--;
        end
        @(posedge clk);
        #1;
        if (stall) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_data", 32'(out_data), 32'(od));
            check("hold_last", 32'(out_last), 32'(ol));
        end
    endtask

    task automatic start_frame(input int l, input logic expect_ok);
        logic t;
        start     = 1'b1;
        len       = LEN_W'(l);
        in_valid  = 1'b0;
        key_valid = 1'b0;
        cyc(t);
        start = 1'b0;
        check("start_take", 32'(t), 32'(0));
        check("start_busy", 32'(busy), 32'(expect_ok));
        check("start_err", 32'(err), 32'(!expect_ok));
        check("start_pad", 32'(pad_left), 32'(pad_model));
        if (expect_ok) model_rem = l;
    endtask

    task automatic reject(input int l);
        logic t;
        start_frame(l, 1'b0);
        cyc(t);
        check("rej_err_end", 32'(err), 32'(0));
        check("rej_idle", 32'(busy), 32'(0));
        check("rej_pad", 32'(pad_left), 32'(pad_model));
    endtask

    // Offer n word pairs, each held until taken.
    task automatic feed(input int n, input logic [WORD_W-1:0] bi, input logic [WORD_W-1:0] bk);
        logic t;
        int   g;
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            key_valid = 1'b1;
            in_data   = bi + 16'(i);
            key_data  = bk ^ 16'(i * 257);
            g = 0;
            do begin
                cyc(t);
                g++;
            end while (!t && g < 20);
            check("feed_take", 32'(t), 32'(1));
        end
        in_valid  = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic finish_frame();
        logic t;
        int   n;
        in_valid  = 1'b0;
        key_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        do begin
            cyc(t);
            n++;
        end while (!done && n < 20);
        check("done_seen", 32'(done), 32'(1));
        check("done_busy", 32'(busy), 32'(0));
        check("drained", 32'(exp_q.size()), 32'(0));
        check("frame_pad", 32'(pad_left), 32'(pad_model));
        cyc(t);
        check("done_pulse", 32'(done), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        last_q.delete();
        pad_model = PAD_WORDS;
        model_rem = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        logic t;
        tbl[0] = '{16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[2] = '{16'hAAAA, 16'h5555, 16'hFFFF};
        tbl[3] = '{16'h5555, 16'h5555, 16'h0000};
        tbl[4] = '{16'hFFFF, 16'h5555, 16'hAAAA};

        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; key_valid = 1'b0; key_data = '0;
        out_ready = 1'b1;
        pad_model = PAD_WORDS; model_rem = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_key_ready", 32'(key_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_pad", 32'(pad_left), 32'(64));
        rst = 1'b0;

        // Basic XOR from the table, one word per cycle
        start_frame(5, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; key_valid = 1'b1;
            in_data = tbl[i].din; key_data = tbl[i].key;
            cyc(t);
            check("basic_take", 32'(t), 32'(1));
            check("basic_valid", 32'(out_valid), 32'(1));
            check("basic_out", 32'(out_data), 32'(tbl[i].exp));
            check("basic_last", 32'(out_last), 32'(i == 4));
        end
        in_valid = 1'b0; key_valid = 1'b0;
        cyc(t);
        check("basic_done", 32'(done), 32'(1));
        check("basic_busy", 32'(busy), 32'(0));
        check("basic_vld_drop", 32'(out_valid), 32'(0));
        cyc(t);
        check("basic_done_end", 32'(done), 32'(0));
        check("basic_pad", 32'(pad_left), 32'(59));

        // Backpressure: sink stalls three cycles with a word pair waiting
        start_frame(6, 1'b1);
        out_ready = 1'b1;
        feed(2, 16'h1000, 16'h0F0F);
        in_valid = 1'b1; key_valid = 1'b1;
        in_data = 16'h1002; key_data = 16'h0D0D;
        out_ready = 1'b0;
        repeat (3) begin
            cyc(t);
            check("bp_no_take", 32'(t), 32'(0));
        end
        out_ready = 1'b1;
        feed(4, 16'h1002, 16'h0D0D);
        finish_frame();
        check("bp_pad", 32'(pad_left), 32'(53));

        // Stream skew: pad stream lags the message stream by four cycles
        start_frame(4, 1'b1);
        in_valid = 1'b1; in_data = 16'h3000;
        key_valid = 1'b0; key_data = 16'h0000;
        repeat (4) begin
            cyc(t);
            check("skew_no_take", 32'(t), 32'(0));
        end
        feed(4, 16'h3000, 16'hC3C3);
        finish_frame();
        check("skew_pad", 32'(pad_left), 32'(49));

        // len=0 rejected; the largest legal length (15) is accepted below,
        // since 16 does not fit the default 4-bit length port.
        reject(0);

        // Reset after 2 of 8 words
        start_frame(8, 1'b1);
        feed(2, 16'h4000, 16'h1234);
        in_valid = 1'b1; key_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_in_ready", 32'(in_ready), 32'(0));
        check("mid_key_ready", 32'(key_ready), 32'(0));
        check("mid_out_valid", 32'(out_valid), 32'(0));
        check("mid_out_data", 32'(out_data), 32'(0));
        check("mid_out_last", 32'(out_last), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_done", 32'(done), 32'(0));
        check("mid_err", 32'(err), 32'(0));
        check("mid_pad", 32'(pad_left), 32'(64));
        rst = 1'b0;
        in_valid = 1'b0; key_valid = 1'b0;
        exp_q.delete(); last_q.delete();
        pad_model = PAD_WORDS; model_rem = 0;
        start_frame(3, 1'b1);
        feed(3, 16'h5000, 16'hBEEF);
        finish_frame();
        check("mid_new_pad", 32'(pad_left), 32'(61));

        // Pad exhaustion: 15,15,15,15 then 10 rejected, 4 accepted, then empty
        do_reset();
        for (int k = 0; k < 4; k++) begin
            start_frame(15, 1'b1);
            feed(15, 16'(16'h6000 + k * 16'h0100), 16'h9A5C);
            finish_frame();
        end
        check("exh_pad4", 32'(pad_left), 32'(4));
        reject(10);
        start_frame(4, 1'b1);
        feed(4, 16'h7000, 16'h0FF0);
        finish_frame();
        check("exh_pad0", 32'(pad_left), 32'(0));
        reject(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
